// File: rtl/life_pkg.sv
// Shared types and defaults for the Game of Life sequencer.
package life_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } life_state_t;

  localparam int unsigned GEN_W_DEFAULT = 16;

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw button, emitting a one-cycle pulse on each accepted press.
module button_conditioner #(
  parameter int unsigned debounce_cycles = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // The accepted level only follows the synchronized input after it has differed for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync_q2;
        press  <= sync_q2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/life_controller.sv
// Sequencer deciding when the cell array loads its seed and when it advances a generation.
module life_controller #(
  parameter int unsigned game_divider    = 1,
  parameter int unsigned debounce_cycles = 1000,
  parameter int unsigned frame_sync      = 1,
  parameter int unsigned GEN_W           = life_pkg::GEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             frame_done,
  output logic             load_seed,
  output logic             step_game,
  output logic             running,
  output logic [GEN_W-1:0] generation,
  output logic             overrun
);

  import life_pkg::*;

  localparam int unsigned DIV_W = (game_divider > 1) ? $clog2(game_divider) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(game_divider - 1);
  localparam bit SYNC = (frame_sync != 0);

  life_state_t      state;
  logic [DIV_W-1:0] div_cnt;
  logic             pending;
  logic             run_press;
  logic             step_press;
  logic             tick_c;
  logic             issue_c;

  button_conditioner #(.debounce_cycles(debounce_cycles)) u_run_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_run),
    .press (run_press)
  );

  button_conditioner #(.debounce_cycles(debounce_cycles)) u_step_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_step),
    .press (step_press)
  );

  assign tick_c = (div_cnt == DIV_LAST);

  // A run press cancels any step due on the same edge; a step press only counts while paused.
  always_comb begin
    issue_c = 1'b0;
    if (!run_press) begin
      case (state)
        RUN:     issue_c = SYNC ? ((pending || tick_c) && frame_done) : tick_c;
        PAUSED:  issue_c = SYNC ? ((pending || step_press) && frame_done) : step_press;
        default: issue_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEED;
      div_cnt    <= '0;
      pending    <= 1'b0;
      load_seed  <= 1'b0;
      step_game  <= 1'b0;
      running    <= 1'b0;
      generation <= '0;
      overrun    <= 1'b0;
    end else begin
      load_seed <= 1'b0;
      step_game <= issue_c;
      if (issue_c) begin
        generation <= generation + GEN_W'(1);
        pending    <= 1'b0;
      end
      case (state)
        SEED: begin
          load_seed <= 1'b1;
          running   <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (run_press) begin
            state   <= PAUSED;
            running <= 1'b0;
            div_cnt <= '0;
            pending <= 1'b0;
          end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (SYNC && tick_c) begin
              if (pending) overrun <= 1'b1;
              if (!issue_c) pending <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (run_press) begin
            state   <= RUN;
            running <= 1'b1;
            div_cnt <= '0;
            pending <= 1'b0;
          end else if (SYNC && step_press && !issue_c) begin
            pending <= 1'b1;
          end
        end
        default: begin
          state   <= SEED;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_controller.sv
// Randomized scoreboard bench: free-running (inst 0) and frame-synchronous (inst 1) controllers.
module tb_life_controller;

  localparam int DEB = 2;
  localparam int PRESS_LAT = 2 + DEB;

  typedef struct packed {
    logic        ls;
    logic        sg;
    logic        run;
    logic [15:0] gen;
    logic        ov;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic        frame_done = 1'b0;
  logic        a_load_seed, a_step_game, a_running, a_overrun;
  logic        b_load_seed, b_step_game, b_running, b_overrun;
  logic [15:0] a_generation, b_generation;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  bit fd_periodic = 1'b0;
  bit run_ev[int];
  bit step_ev[int];

  // Reference model state, index 0 = free-running, 1 = frame-synchronous
  int mode[2];   // 0 seeding, 1 running, 2 paused
  int since[2];  // edges spent in the current run interval
  int gen[2];
  bit pend[2];
  bit ov[2];
  int div_of[2] = '{3, 2};

  obs_t q0[$];
  obs_t q1[$];

  life_controller #(.game_divider(3), .debounce_cycles(DEB), .frame_sync(0), .GEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .frame_done(frame_done),
    .load_seed(a_load_seed), .step_game(a_step_game), .running(a_running),
    .generation(a_generation), .overrun(a_overrun)
  );

  life_controller #(.game_divider(2), .debounce_cycles(DEB), .frame_sync(1), .GEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .frame_done(frame_done),
    .load_seed(b_load_seed), .step_game(b_step_game), .running(b_running),
    .generation(b_generation), .overrun(b_overrun)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
    end
  endtask

  function automatic void model_reset(int i);
    mode[i] = 0; since[i] = 0; gen[i] = 0; pend[i] = 1'b0; ov[i] = 1'b0;
  endfunction

  function automatic obs_t model_step(int i, bit rp, bit sp, bit fd);
    obs_t o;
    bit issue;
    bit tick;
    o = '0;
    issue = 1'b0;
    if (mode[i] == 0) begin
      o.ls = 1'b1;
      mode[i] = 1;
      since[i] = 0;
    end else if (rp) begin
      mode[i] = (mode[i] == 1) ? 2 : 1;
      since[i] = 0;
      pend[i] = 1'b0;
    end else if (mode[i] == 1) begin
      tick = ((since[i] % div_of[i]) == div_of[i] - 1);
      since[i]++;
      if (i == 0) issue = tick;
      else begin
        if (tick && pend[i]) ov[i] = 1'b1;
        if ((pend[i] || tick) && fd) begin issue = 1'b1; pend[i] = 1'b0; end
        else if (tick) pend[i] = 1'b1;
      end
    end else begin
      if (i == 0) issue = sp;
      else if ((pend[i] || sp) && fd) begin issue = 1'b1; pend[i] = 1'b0; end
      else if (sp) pend[i] = 1'b1;
    end
    if (issue) gen[i] = (gen[i] + 1) % 65536;
    o.sg  = issue;
    o.run = (mode[i] == 1);
    o.gen = 16'(gen[i]);
    o.ov  = ov[i];
    return o;
  endfunction

  // Model: predict each instance's outputs after every edge
  always @(posedge clk) begin
    bit rp;
    bit sp;
    edge_n++;
    rp = run_ev.exists(edge_n);
    sp = step_ev.exists(edge_n);
    for (int i = 0; i < 2; i++) begin
      if (rst) model_reset(i);
      if (i == 0) q0.push_back(rst ? obs_t'('0) : model_step(0, rp, sp, frame_done));
      else        q1.push_back(rst ? obs_t'('0) : model_step(1, rp, sp, frame_done));
    end
  end

  // Monitor: pop the prediction and compare against what each DUT presents
  always @(posedge clk) begin
    obs_t e;
    #2;
    if (q0.size() == 0) cmp("a.queue_empty", 1, 0);
    else begin
      e = q0.pop_front();
      cmp("a.load_seed", int'(a_load_seed), int'(e.ls));
      cmp("a.step_game", int'(a_step_game), int'(e.sg));
      cmp("a.running", int'(a_running), int'(e.run));
      cmp("a.generation", int'(a_generation), int'(e.gen));
      cmp("a.overrun", int'(a_overrun), int'(e.ov));
    end
    if (q1.size() == 0) cmp("b.queue_empty", 1, 0);
    else begin
      e = q1.pop_front();
      cmp("b.load_seed", int'(b_load_seed), int'(e.ls));
      cmp("b.step_game", int'(b_step_game), int'(e.sg));
      cmp("b.running", int'(b_running), int'(e.run));
      cmp("b.generation", int'(b_generation), int'(e.gen));
      cmp("b.overrun", int'(b_overrun), int'(e.ov));
    end
  end

  task automatic step_cycle();
    @(negedge clk);
    if (fd_periodic) frame_done = (((edge_n + 1) % 5) == 0);
    else frame_done = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(int n);
    repeat (n) step_cycle();
  endtask

  // Raw press held for 'hold' edges; the controller sees it PRESS_LAT edges after the first sample
  task automatic press(bit r, bit s, int hold);
    int first;
    step_cycle();
    first = edge_n + 1;
    if (r) btn_run = 1'b1;
    if (s) btn_step = 1'b1;
    if (hold >= DEB) begin
      if (r) run_ev[first + PRESS_LAT] = 1'b1;
      if (s) step_ev[first + PRESS_LAT] = 1'b1;
    end
    repeat (hold - 1) step_cycle();
    step_cycle();
    btn_run = 1'b0;
    btn_step = 1'b0;
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("rst.a_outputs", int'({a_load_seed, a_step_game, a_running, a_overrun}), 0);
    cmp("rst.a_generation", int'(a_generation), 0);
    cmp("rst.b_outputs", int'({b_load_seed, b_step_game, b_running, b_overrun}), 0);
    cmp("rst.b_generation", int'(b_generation), 0);
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    fd_periodic = 1'b1;
    idle(40);
    press(1'b1, 1'b0, 10);
    idle(50);
    for (int k = 0; k < 3; k++) begin
      press(1'b0, 1'b1, 3);
      idle(17);
    end
    fd_periodic = 1'b0;
    press(1'b1, 1'b1, 4);
    idle(30);
    press(1'b1, 1'b0, 3);
    idle(20);
    press(1'b0, 1'b1, 1);
    idle(20);
    press(1'b0, 1'b1, 2);
    idle(20);
    for (int k = 0; k < 30; k++) begin
      bit r;
      bit s;
      idle($urandom_range(15, 30));
      r = 1'($urandom_range(0, 1));
      s = r ? 1'($urandom_range(0, 1)) : 1'b1;
      press(r, s, $urandom_range(1, 5));
    end
    idle(20);
    async_reset_check();
    idle(40);
    async_reset_check();
    idle(20);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
